// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg
//   Shared constants and types for the polyphonic voice allocator:
//   MIDI field widths, the allocator state encoding and a clog2 helper
//   used to size per-channel age counters and channel indices.
package voice_allocator_pkg;

  localparam int MIDI_KEY_W = 7;
  localparam int MIDI_VEL_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    CLEAR
  } state_t;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// voice_age_tracker
//   Keeps a least-recently-used ordering of the voices as a permutation of
//   ages 0..NUM_CHANNELS-1 (0 = most recently allocated, NUM_CHANNELS-1 =
//   oldest). A touch strobe moves 'target' to age 0 and ages every channel
//   that was younger than it by one, so the set stays a permutation.
// Ports:
//   clk, rst  clock and asynchronous active-high reset (ages reset to c)
//   touch     update strobe
//   target    channel being allocated
//   ages      per-channel age
module voice_age_tracker
  import voice_allocator_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  localparam int AGE_W = clog2(NUM_CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                touch,
  input  logic [AGE_W-1:0]                    target,
  output logic [NUM_CHANNELS-1:0][AGE_W-1:0]  ages
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ages[c] <= AGE_W'(c);
      end
    end else if (touch) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (AGE_W'(c) == target) begin
          ages[c] <= '0;
        end else if (ages[c] < ages[target]) begin
          ages[c] <= ages[c] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphonic voice scheduler between the MIDI event decoder and the note
//   register / envelope bank. Each accepted event is scanned against every
//   channel (one channel per cycle), then a note-on is written to the
//   retriggered key, the lowest free channel, or the oldest voice, and a
//   note-off releases the first gated voice holding that key.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ev_valid/ev_ready event handshake
//   ev_note_on, ev_key, ev_velocity, ev_word  event fields
//   all_off           panic release of every voice, aborts in-flight event
//   available         per-channel envelope idle flags from the bank
//   reg_en            one-hot single-cycle load strobe
//   note_en           per-channel gate levels
//   note_word         tuning word accompanying reg_en
//   velocity_out      flat per-channel 32-bit gain words
//   busy              allocator is not in IDLE
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_BITS_IN  = 18,
  parameter int VEL_SHIFT    = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_note_on,
  input  logic [MIDI_KEY_W-1:0]      ev_key,
  input  logic [MIDI_VEL_W-1:0]      ev_velocity,
  input  logic [NUM_BITS_IN-1:0]     ev_word,
  input  logic                       all_off,
  input  logic [NUM_CHANNELS-1:0]    available,
  output logic [NUM_CHANNELS-1:0]    reg_en,
  output logic [NUM_CHANNELS-1:0]    note_en,
  output logic [NUM_BITS_IN-1:0]     note_word,
  output logic [NUM_CHANNELS*32-1:0] velocity_out,
  output logic                       busy
);

  localparam int AGE_W = clog2(NUM_CHANNELS);
  localparam logic [AGE_W-1:0] LAST = AGE_W'(NUM_CHANNELS - 1);

  state_t                                  state;
  logic                                    armed;
  logic [AGE_W-1:0]                        idx;
  logic                                    cap_on;
  logic [MIDI_KEY_W-1:0]                   cap_key;
  logic [MIDI_VEL_W-1:0]                   cap_vel;
  logic [NUM_BITS_IN-1:0]                  cap_word;
  logic                                    match_found;
  logic                                    free_found;
  logic [AGE_W-1:0]                        match_idx;
  logic [AGE_W-1:0]                        free_idx;
  logic [AGE_W-1:0]                        old_idx;
  logic [NUM_CHANNELS-1:0]                 key_valid;
  logic [NUM_CHANNELS-1:0][MIDI_KEY_W-1:0] keys;
  logic [NUM_CHANNELS-1:0][31:0]           vel_q;
  logic [NUM_CHANNELS-1:0][AGE_W-1:0]      ages;
  logic [AGE_W-1:0]                        target;
  logic                                    touch;
  logic                                    key_hit;

  // 'armed' keeps ev_ready low until the first clock after reset release.
  assign ev_ready     = armed && (state == IDLE) && !all_off;
  assign busy         = (state != IDLE);
  assign velocity_out = vel_q;
  assign key_hit      = key_valid[idx] && (keys[idx] == cap_key);
  assign target       = match_found ? match_idx : (free_found ? free_idx : old_idx);
  // all_off overriding WRITE must leave the age order untouched as well.
  assign touch        = (state == WRITE) && !all_off;

  voice_age_tracker #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .touch (touch),
    .target(target),
    .ages  (ages)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      idx         <= '0;
      cap_on      <= 1'b0;
      cap_key     <= '0;
      cap_vel     <= '0;
      cap_word    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      key_valid   <= '0;
      keys        <= '0;
      vel_q       <= '0;
      reg_en      <= '0;
      note_en     <= '0;
      note_word   <= '0;
    end else begin
      armed  <= 1'b1;
      reg_en <= '0;
      if (all_off) begin
        note_en <= '0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid && ev_ready) begin
              // Velocity-0 note-on is folded into note-off at capture time.
              cap_on      <= ev_note_on && (ev_velocity != '0);
              cap_key     <= ev_key;
              cap_vel     <= ev_velocity;
              cap_word    <= ev_word;
              idx         <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              state       <= SCAN;
            end
          end
          SCAN: begin
            if (cap_on) begin
              if (!match_found && key_hit) begin
                match_found <= 1'b1;
                match_idx   <= idx;
              end
              if (!free_found && available[idx]) begin
                free_found <= 1'b1;
                free_idx   <= idx;
              end
              if (ages[idx] == LAST) begin
                old_idx <= idx;
              end
            end else if (!match_found && key_hit && note_en[idx]) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            if (idx == LAST) begin
              state <= cap_on ? WRITE : CLEAR;
            end else begin
              idx <= idx + AGE_W'(1);
            end
          end
          WRITE: begin
            reg_en            <= NUM_CHANNELS'(1) << target;
            note_word         <= cap_word;
            note_en[target]   <= 1'b1;
            vel_q[target]     <= 32'(cap_vel) << VEL_SHIFT;
            keys[target]      <= cap_key;
            key_valid[target] <= 1'b1;
            state             <= IDLE;
          end
          CLEAR: begin
            if (match_found) begin
              note_en[match_idx] <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Self-checking bench for voice_allocator: a table of hand-worked events,
//   hand-written sequences for all_off abort, reset during WRITE and voice
//   stealing, and a randomized phase checked against a behavioural model
//   that tracks voices with plain arrays and an LRU queue.
module tb_voice_allocator;

  localparam int N  = 16;
  localparam int W  = 18;
  localparam int VS = 25;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ev_valid = 1'b0;
  logic           ev_ready;
  logic           ev_note_on = 1'b0;
  logic [6:0]     ev_key = '0;
  logic [6:0]     ev_velocity = '0;
  logic [W-1:0]   ev_word = '0;
  logic           all_off = 1'b0;
  logic [N-1:0]   available = '1;
  logic [N-1:0]   reg_en;
  logic [N-1:0]   note_en;
  logic [W-1:0]   note_word;
  logic [N*32-1:0] velocity_out;
  logic           busy;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_CHANNELS(N), .NUM_BITS_IN(W), .VEL_SHIFT(VS)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_note_on(ev_note_on), .ev_key(ev_key), .ev_velocity(ev_velocity),
    .ev_word(ev_word), .all_off(all_off), .available(available),
    .reg_en(reg_en), .note_en(note_en), .note_word(note_word),
    .velocity_out(velocity_out), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: per-voice key/gate/gain and an LRU queue whose
  // last entry is the oldest voice.
  logic [6:0]   m_key[N];
  bit           m_kv[N];
  bit           m_gate[N];
  logic [31:0]  m_vel[N];
  logic [W-1:0] m_word;
  int           lru[$];

  typedef struct {
    bit           on;
    logic [6:0]   key;
    logic [6:0]   vel;
    logic [W-1:0] word;
    logic [N-1:0] avail;
    logic [N-1:0] exp_reg;
    logic [N-1:0] exp_gate;
  } vec_t;

  vec_t vectors[7];

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    lru.delete();
    for (int c = 0; c < N; c++) begin
      m_key[c] = '0; m_kv[c] = 1'b0; m_gate[c] = 1'b0; m_vel[c] = '0;
      lru.push_back(c);
    end
    m_word = '0;
  endtask

  task automatic modelAllOff();
    for (int c = 0; c < N; c++) m_gate[c] = 1'b0;
  endtask

  function automatic logic [N-1:0] modelGates();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = m_gate[c];
    return r;
  endfunction

  function automatic logic [511:0] modelVel();
    logic [511:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[c*32 +: 32] = m_vel[c];
    return r;
  endfunction

  // Applies the allocation rules to the model; returns the expected strobe.
  task automatic modelEvent(input bit on, input logic [6:0] k, input logic [6:0] v,
                            input logic [W-1:0] w, input logic [N-1:0] av,
                            output logic [N-1:0] exp_reg);
    int tgt;
    tgt = -1;
    exp_reg = '0;
    if (on && v != 0) begin
      for (int c = 0; c < N && tgt < 0; c++) if (m_kv[c] && m_key[c] == k) tgt = c;
      for (int c = 0; c < N && tgt < 0; c++) if (av[c]) tgt = c;
      if (tgt < 0) tgt = lru[N-1];
      exp_reg[tgt] = 1'b1;
      m_gate[tgt] = 1'b1;
      m_key[tgt] = k;
      m_kv[tgt] = 1'b1;
      m_vel[tgt] = 32'(longint'(v) * (longint'(1) << VS));
      m_word = w;
      for (int p = 0; p < lru.size(); p++) begin
        if (lru[p] == tgt) begin
          lru.delete(p);
          break;
        end
      end
      lru.push_front(tgt);
    end else begin
      for (int c = 0; c < N; c++) begin
        if (m_gate[c] && m_kv[c] && m_key[c] == k) begin
          m_gate[c] = 1'b0;
          break;
        end
      end
    end
  endtask

  // Waits for ev_ready (bounded) at a falling edge and presents the event.
  task automatic startEvent(input bit on, input logic [6:0] k, input logic [6:0] v,
                            input logic [W-1:0] w, input logic [N-1:0] av, output bit ok);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!ev_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ev_ready_before_event", 512'(ev_ready), 512'(1));
    ok = ev_ready;
    if (ok) begin
      ev_valid = 1'b1; ev_note_on = on; ev_key = k; ev_velocity = v;
      ev_word = w; available = av;
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
    end
  endtask

  // Runs one full event and checks every output against the model.
  task automatic applyStimulus(input bit on, input logic [6:0] k, input logic [6:0] v,
                               input logic [W-1:0] w, input logic [N-1:0] av,
                               output logic [N-1:0] seen);
    bit ok;
    logic [N-1:0] exp_reg;
    seen = '0;
    startEvent(on, k, v, w, av, ok);
    if (!ok) return;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("ev_ready_low_in_scan", 512'(ev_ready), 512'(0));
    checkOutput("busy_in_scan", 512'(busy), 512'(1));
    @(posedge clk);
    #1;
    seen = reg_en;
    modelEvent(on, k, v, w, av, exp_reg);
    checkOutput("reg_en", 512'(reg_en), 512'(exp_reg));
    checkOutput("note_en", 512'(note_en), 512'(modelGates()));
    checkOutput("note_word", 512'(note_word), 512'(m_word));
    checkOutput("velocity_out", velocity_out, modelVel());
    checkOutput("ev_ready_after_event", 512'(ev_ready), 512'(1));
    @(posedge clk);
    #1;
    checkOutput("reg_en_single_cycle", 512'(reg_en), 512'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_reg_en"}, 512'(reg_en), 512'(0));
    checkOutput({tag, "_note_en"}, 512'(note_en), 512'(0));
    checkOutput({tag, "_note_word"}, 512'(note_word), 512'(0));
    checkOutput({tag, "_velocity"}, velocity_out, 512'(0));
    checkOutput({tag, "_ev_ready"}, 512'(ev_ready), 512'(0));
    checkOutput({tag, "_busy"}, 512'(busy), 512'(0));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    ev_valid = 1'b0; all_off = 1'b0; available = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [N-1:0] seen;
    logic [N-1:0] av;
    logic [N-1:0] strobes;
    bit ok;

    vectors[0] = '{1'b1, 7'd60, 7'd100, 18'h01234, 16'hFFFF, 16'h0001, 16'h0001};
    vectors[1] = '{1'b1, 7'd62, 7'd50,  18'h02000, 16'hFFFE, 16'h0002, 16'h0003};
    vectors[2] = '{1'b1, 7'd64, 7'd70,  18'h03000, 16'hFFFC, 16'h0004, 16'h0007};
    vectors[3] = '{1'b0, 7'd60, 7'd0,   18'h00000, 16'hFFFC, 16'h0000, 16'h0006};
    vectors[4] = '{1'b1, 7'd62, 7'd90,  18'h02222, 16'hFFFC, 16'h0002, 16'h0006};
    vectors[5] = '{1'b0, 7'd99, 7'd40,  18'h00000, 16'hFFFC, 16'h0000, 16'h0006};
    vectors[6] = '{1'b1, 7'd33, 7'd0,   18'h00111, 16'hFFFC, 16'h0000, 16'h0006};

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1 checkResetOutputs("reset");
    doReset();

    // Hand-worked vectors.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i].on, vectors[i].key, vectors[i].vel, vectors[i].word,
                    vectors[i].avail, seen);
      checkOutput($sformatf("vec%0d_reg_en", i), 512'(seen), 512'(vectors[i].exp_reg));
      checkOutput($sformatf("vec%0d_note_en", i), 512'(note_en), 512'(vectors[i].exp_gate));
    end
    checkOutput("vec0_velocity_slice", 512'(velocity_out[31:0]), 512'(32'd3355443200));

    // all_off during SCAN of a note-on: dropped, gates cleared, back to IDLE.
    startEvent(1'b1, 7'd70, 7'd10, 18'h0ABCD, 16'hFFFF, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_note_en", 512'(note_en), 512'(0));
    checkOutput("abort_reg_en", 512'(reg_en), 512'(0));
    checkOutput("abort_busy", 512'(busy), 512'(0));
    checkOutput("abort_ready_while_all_off", 512'(ev_ready), 512'(0));
    @(negedge clk);
    all_off = 1'b0;
    modelAllOff();
    strobes = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 strobes |= reg_en;
    end
    checkOutput("abort_no_strobe", 512'(strobes), 512'(0));
    checkOutput("abort_ready_after", 512'(ev_ready), 512'(1));

    // Reset asserted in the middle of a WRITE cycle.
    applyStimulus(1'b1, 7'd72, 7'd127, 18'h3FFFF, 16'hFFFF, seen);
    startEvent(1'b1, 7'd74, 7'd5, 18'h15555, 16'hFFFF, ok);
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkResetOutputs("reset_in_write");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Sixteen voices held busy, then a seventeenth key steals the oldest.
    av = '1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 7'(40 + i), 7'(i + 1), W'(i * 100 + 1), av, seen);
      av[i] = 1'b0;
    end
    applyStimulus(1'b1, 7'd90, 7'd127, 18'h2AAAA, av, seen);
    checkOutput("steal_reg_en", 512'(seen), 512'(16'h0001));
    applyStimulus(1'b0, 7'd90, 7'd0, 18'h0, av, seen);
    checkOutput("steal_key90_release", 512'(note_en), 512'(16'hFFFE));

    // Randomized events against the model, with occasional panics.
    doReset();
    for (int i = 0; i < 40; i++) begin
      logic [6:0] k;
      logic [6:0] v;
      k = 7'(50 + $urandom_range(0, 7));
      v = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      av = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom & $urandom & $urandom);
      applyStimulus($urandom_range(0, 2) != 0, k, v, W'($urandom), av, seen);
      if (i % 10 == 9) begin
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        modelAllOff();
        checkOutput("random_all_off", 512'(note_en), 512'(modelGates()));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
